// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcode/funct encodings, widths, decoded control
// and the ID/EX pipeline-register layout.
package cpu_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src_imm;
    logic             uses_rs;
    logic             uses_rt;
    logic [REG_W-1:0] rd;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src_imm;
    logic [REG_W-1:0]  rd;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  function automatic logic [DATA_W-1:0] ext_imm16(input logic [15:0] imm, input logic sign_en);
    return sign_en ? {{(DATA_W-16){imm[15]}}, imm} : {{(DATA_W-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: youngest in-flight producer wins over the regfile.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter bit R0_IS_ZERO = 1'b1
) (
  input  logic [REG_W-1:0]  src_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              ex_en_i,
  input  logic [REG_W-1:0]  ex_rd_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              mem_en_i,
  input  logic [REG_W-1:0]  mem_rd_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_en_i,
  input  logic [REG_W-1:0]  wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);

  // NOTE: a complete if/else chain (or a default assigned first) keeps combinational logic latch-free.
  always_comb begin
    if (R0_IS_ZERO && src_i == '0)                data_o = '0;
    else if (ex_en_i && ex_rd_i == src_i)         data_o = ex_data_i;
    else if (mem_en_i && mem_rd_i == src_i)       data_o = mem_data_i;
    else if (wb_en_i && wb_rd_i == src_i)         data_o = wb_data_i;
    else                                          data_o = rf_data_i;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: decodes IF/ID, bypasses operands from EX/MEM/WB,
// inserts a one-cycle bubble on load-use, and registers the result into ID/EX.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter bit R0_IS_ZERO = 1'b1,
  parameter bit IMM_SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic [31:0]       ex_result,
  input  logic              mem_wr_en,
  input  logic [4:0]        mem_wr_reg,
  input  logic [31:0]       mem_data,
  input  logic              wb_wr_en,
  input  logic [4:0]        wb_wr_reg,
  input  logic [31:0]       wb_data,
  input  logic              stall_in,
  input  logic              flush,
  output logic              stall_out,
  output logic              out_valid,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_alu_src_imm,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_op_a,
  output logic [31:0]       out_op_b,
  output logic [31:0]       out_imm,
  output logic [4:0]        out_rd,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct
);

  id_ex_t id_ex_q, id_ex_d;
  ctrl_t  ctrl;

  logic [5:0]        opcode;
  logic [REG_W-1:0]  rs, rt;
  logic [DATA_W-1:0] op_a_fwd, op_b_fwd;
  logic              ex_fwd_en, load_use;

  assign opcode    = in_instr[31:26];
  assign rs        = in_instr[25:21];
  assign rt        = in_instr[20:16];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.uses_rs   = 1'b1;
        ctrl.uses_rt   = 1'b1;
        ctrl.rd        = in_instr[15:11];
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.uses_rs     = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_read    = (opcode == OP_LW);
        ctrl.rd          = rt;
      end
      OP_SW: begin
        ctrl.uses_rs     = 1'b1;
        ctrl.uses_rt     = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // A load still in EX has no data yet, so it must never be an EX bypass source.
  assign ex_fwd_en = id_ex_q.valid & id_ex_q.reg_write & ~id_ex_q.mem_read;

  fwd_mux #(.R0_IS_ZERO(R0_IS_ZERO)) u_fwd_a (
    .src_i(rs), .rf_data_i(rf_rdata1),
    .ex_en_i(ex_fwd_en), .ex_rd_i(id_ex_q.rd), .ex_data_i(ex_result),
    .mem_en_i(mem_wr_en), .mem_rd_i(mem_wr_reg), .mem_data_i(mem_data),
    .wb_en_i(wb_wr_en), .wb_rd_i(wb_wr_reg), .wb_data_i(wb_data),
    .data_o(op_a_fwd)
  );

  fwd_mux #(.R0_IS_ZERO(R0_IS_ZERO)) u_fwd_b (
    .src_i(rt), .rf_data_i(rf_rdata2),
    .ex_en_i(ex_fwd_en), .ex_rd_i(id_ex_q.rd), .ex_data_i(ex_result),
    .mem_en_i(mem_wr_en), .mem_rd_i(mem_wr_reg), .mem_data_i(mem_data),
    .wb_en_i(wb_wr_en), .wb_rd_i(wb_wr_reg), .wb_data_i(wb_data),
    .data_o(op_b_fwd)
  );

  function automatic logic load_hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] ld_rd);
    return !(R0_IS_ZERO && src == '0) && (src == ld_rd);
  endfunction

  assign load_use = in_valid & id_ex_q.valid & id_ex_q.mem_read &
                    ((ctrl.uses_rs & load_hit(rs, id_ex_q.rd)) |
                     (ctrl.uses_rt & load_hit(rt, id_ex_q.rd)));

  assign stall_out = ~rst & (load_use | stall_in);

  always_comb begin
    id_ex_d = id_ex_q;
    if (flush) begin
      id_ex_d = '0;
    end else if (stall_in) begin
      id_ex_d = id_ex_q;
    end else if (load_use || !in_valid) begin
      id_ex_d = '0;
    end else begin
      id_ex_d.valid       = 1'b1;
      id_ex_d.reg_write   = ctrl.reg_write;
      id_ex_d.mem_read    = ctrl.mem_read;
      id_ex_d.mem_write   = ctrl.mem_write;
      id_ex_d.alu_src_imm = ctrl.alu_src_imm;
      id_ex_d.rd          = ctrl.rd;
      id_ex_d.opcode      = opcode;
      id_ex_d.funct       = in_instr[5:0];
      id_ex_d.pc          = in_pc;
      id_ex_d.op_a        = op_a_fwd;
      id_ex_d.op_b        = op_b_fwd;
      id_ex_d.imm         = ext_imm16(in_instr[15:0], IMM_SIGNED);
    end
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign out_valid       = id_ex_q.valid;
  assign out_reg_write   = id_ex_q.reg_write;
  assign out_mem_read    = id_ex_q.mem_read;
  assign out_mem_write   = id_ex_q.mem_write;
  assign out_alu_src_imm = id_ex_q.alu_src_imm;
  assign out_pc          = id_ex_q.pc;
  assign out_op_a        = id_ex_q.op_a;
  assign out_op_b        = id_ex_q.op_b;
  assign out_imm         = id_ex_q.imm;
  assign out_rd          = id_ex_q.rd;
  assign out_opcode      = id_ex_q.opcode;
  assign out_funct       = id_ex_q.funct;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vectors, an ID/EX reference model
// compared every cycle, and hand-computed spot checks.
module tb_operand_fetch_stage;
  import cpu_pkg::*;

  logic        clk, rst, in_valid, stall_in, flush;
  logic [31:0] in_instr, in_pc, rf_rdata1, rf_rdata2, ex_result, mem_data, wb_data;
  logic        mem_wr_en, wb_wr_en;
  logic [4:0]  mem_wr_reg, wb_wr_reg, rf_raddr1, rf_raddr2, out_rd;
  logic        stall_out, out_valid, out_reg_write, out_mem_read, out_mem_write, out_alu_src_imm;
  logic [31:0] out_pc, out_op_a, out_op_b, out_imm;
  logic [5:0]  out_opcode, out_funct;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_data(wb_data),
    .stall_in(stall_in), .flush(flush), .stall_out(stall_out),
    .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_alu_src_imm(out_alu_src_imm),
    .out_pc(out_pc), .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct(out_funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: what ID/EX must hold ----------------
  typedef struct {
    bit          v, rw, mr, mw, ai;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rd;
    logic [5:0]  op, fn;
  } exp_t;

  exp_t m;

  function automatic void m_decode(input logic [31:0] ins, output bit rw, output bit mr,
                                   output bit mw, output bit ai, output bit urs,
                                   output bit urt, output logic [4:0] rd);
    {rw, mr, mw, ai, urs, urt} = 6'b0;
    rd = 5'd0;
    case (ins[31:26])
      OP_RTYPE:                  begin rw = 1; urs = 1; urt = 1; rd = ins[15:11]; end
      OP_ADDI, OP_ANDI, OP_ORI,
      OP_SLTI:                   begin rw = 1; urs = 1; ai = 1; rd = ins[20:16]; end
      OP_LW:                     begin rw = 1; urs = 1; ai = 1; mr = 1; rd = ins[20:16]; end
      OP_SW:                     begin urs = 1; urt = 1; mw = 1; ai = 1; end
      OP_BEQ, OP_BNE:            begin urs = 1; urt = 1; end
      default: ;
    endcase
  endfunction

  // Newest value of a register visible to ID this cycle.
  function automatic logic [31:0] m_operand(input logic [4:0] src, input logic [31:0] rf);
    bit          en [3];
    logic [4:0]  r  [3];
    logic [31:0] dv [3];
    if (src == 5'd0) return 32'd0;
    en[0] = m.v && m.rw && !m.mr; r[0] = m.rd;      dv[0] = ex_result;
    en[1] = mem_wr_en;            r[1] = mem_wr_reg; dv[1] = mem_data;
    en[2] = wb_wr_en;             r[2] = wb_wr_reg;  dv[2] = wb_data;
    for (int i = 0; i < 3; i++)
      if (en[i] && r[i] == src) return dv[i];
    return rf;
  endfunction

  function automatic bit m_load_use();
    bit rw, mr, mw, ai, urs, urt;
    logic [4:0] rd;
    logic [4:0] s1, s2;
    m_decode(in_instr, rw, mr, mw, ai, urs, urt, rd);
    s1 = in_instr[25:21];
    s2 = in_instr[20:16];
    return in_valid && m.v && m.mr &&
           ((urs && s1 != 5'd0 && s1 == m.rd) || (urt && s2 != 5'd0 && s2 == m.rd));
  endfunction

  always @(posedge clk) begin
    exp_t nx;
    bit rw, mr, mw, ai, urs, urt;
    logic [4:0] rd;
    nx = m;
    if (rst || flush) nx = '{default: 0};
    else if (stall_in) nx = m;
    else if (!in_valid || m_load_use()) nx = '{default: 0};
    else begin
      m_decode(in_instr, rw, mr, mw, ai, urs, urt, rd);
      nx.v = 1; nx.rw = rw; nx.mr = mr; nx.mw = mw; nx.ai = ai; nx.rd = rd;
      nx.op  = in_instr[31:26];
      nx.fn  = in_instr[5:0];
      nx.pc  = in_pc;
      nx.a   = m_operand(in_instr[25:21], rf_rdata1);
      nx.b   = m_operand(in_instr[20:16], rf_rdata2);
      nx.imm = 32'($signed(in_instr[15:0]));
    end
    m <= nx;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid",     32'(out_valid),       32'(m.v));
      check("reg_write", 32'(out_reg_write),   32'(m.rw));
      check("mem_read",  32'(out_mem_read),    32'(m.mr));
      check("mem_write", 32'(out_mem_write),   32'(m.mw));
      check("alu_imm",   32'(out_alu_src_imm), 32'(m.ai));
      check("pc",        out_pc,               m.pc);
      check("op_a",      out_op_a,             m.a);
      check("op_b",      out_op_b,             m.b);
      check("imm",       out_imm,              m.imm);
      check("rd",        32'(out_rd),          32'(m.rd));
      check("opcode",    32'(out_opcode),      32'(m.op));
      check("funct",     32'(out_funct),       32'(m.fn));
      check("raddr1",    32'(rf_raddr1),       32'(in_instr[25:21]));
      check("raddr2",    32'(rf_raddr2),       32'(in_instr[20:16]));
      check("stall_out", 32'(stall_out),       32'(!rst && (m_load_use() || stall_in)));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_valid  = 1'b1;
    in_instr  = ins;
    rf_rdata1 = r1;
    rf_rdata2 = r2;
  endtask

  task automatic clear_bypass();
    mem_wr_en = 1'b0; mem_wr_reg = 5'd0; mem_data = 32'd0;
    wb_wr_en  = 1'b0; wb_wr_reg  = 5'd0; wb_data  = 32'd0;
  endtask

  logic [31:0] vec [10];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    rf_rdata1 = 32'd0; rf_rdata2 = 32'd0; ex_result = 32'd0;
    stall_in = 1'b0; flush = 1'b0;
    clear_bypass();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stall_out", 32'(stall_out), 32'd0);
    rst = 1'b0;

    // ADD r3,r1,r2 with r1=8, r2=2
    drive(enc_r(5'd1, 5'd2, 5'd3, FN_ADD), 32'd8, 32'd2);
    in_pc = 32'h100;
    step();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_op_a",  out_op_a, 32'd8);
    check("add_op_b",  out_op_b, 32'd2);
    check("add_rd",    32'(out_rd), 32'd3);
    check("add_rw",    32'(out_reg_write), 32'd1);

    // SUB r4,r3,r1: r3 comes from EX
    drive(enc_r(5'd3, 5'd1, 5'd4, FN_SUB), 32'd99, 32'd8);
    in_pc = 32'h104; ex_result = 32'd10;
    #1 check("sub_no_stall", 32'(stall_out), 32'd0);
    step();
    check("sub_ex_bypass", out_op_a, 32'd10);
    check("sub_rd", 32'(out_rd), 32'd4);

    // LW r5,0(r1) then ADD r6,r5,r2
    drive(enc_i(OP_LW, 5'd1, 5'd5, 16'd0), 32'd8, 32'd0);
    in_pc = 32'h108;
    step();
    check("lw_mem_read", 32'(out_mem_read), 32'd1);
    check("lw_rd", 32'(out_rd), 32'd5);
    drive(enc_r(5'd5, 5'd2, 5'd6, FN_ADD), 32'd0, 32'd2);
    in_pc = 32'h10C; ex_result = 32'd8;
    #1 check("lu_stall", 32'(stall_out), 32'd1);
    step();
    check("lu_bubble", 32'(out_valid), 32'd0);
    mem_wr_en = 1'b1; mem_wr_reg = 5'd5; mem_data = 32'h1234;
    #1 check("lu_released", 32'(stall_out), 32'd0);
    step();
    check("lu_mem_bypass", out_op_a, 32'h1234);
    check("lu_valid", 32'(out_valid), 32'd1);
    clear_bypass();

    // WB bypass, then MEM beats WB
    drive(enc_r(5'd1, 5'd2, 5'd7, FN_ADD), 32'd8, 32'd2);
    wb_wr_en = 1'b1; wb_wr_reg = 5'd2; wb_data = 32'd7;
    step();
    check("wb_bypass", out_op_b, 32'd7);
    mem_wr_en = 1'b1; mem_wr_reg = 5'd2; mem_data = 32'd9;
    step();
    check("mem_over_wb", out_op_b, 32'd9);
    clear_bypass();

    // r0 reads as zero even with bypass writers targeting it
    drive(enc_r(5'd0, 5'd2, 5'd10, FN_OR), 32'd5, 32'd2);
    wb_wr_en = 1'b1; wb_data = 32'h55; mem_wr_en = 1'b1; mem_data = 32'h66;
    step();
    check("r0_zero", out_op_a, 32'd0);
    clear_bypass();

    // sign-extended immediate
    drive(enc_i(OP_ADDI, 5'd1, 5'd9, 16'hFFF0), 32'd8, 32'd3);
    step();
    check("addi_imm", out_imm, 32'hFFFF_FFF0);
    check("addi_rd", 32'(out_rd), 32'd9);

    // downstream hold for 3 cycles, then flush wins over the hold
    drive(enc_r(5'd1, 5'd2, 5'd8, FN_AND), 32'd8, 32'd2);
    step();
    stall_in = 1'b1;
    drive(enc_i(OP_ORI, 5'd1, 5'd11, 16'h00FF), 32'd1, 32'd1);
    for (int k = 0; k < 3; k++) begin
      #1 check("hold_stall_out", 32'(stall_out), 32'd1);
      step();
      check("hold_rd", 32'(out_rd), 32'd8);
      check("hold_op_a", out_op_a, 32'd8);
    end
    flush = 1'b1;
    step();
    check("flush_bubble", 32'(out_valid), 32'd0);
    flush = 1'b0; stall_in = 1'b0;

    // reset in the middle of a load-use stall
    drive(enc_i(OP_LW, 5'd1, 5'd5, 16'd4), 32'd8, 32'd0);
    step();
    drive(enc_r(5'd5, 5'd2, 5'd6, FN_ADD), 32'd0, 32'd2);
    #1 check("pre_rst_stall", 32'(stall_out), 32'd1);
    rst = 1'b1;
    #1 check("rst_drops_stall", 32'(stall_out), 32'd0);
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_mem_read", 32'(out_mem_read), 32'd0);
    check("rst_rd", 32'(out_rd), 32'd0);
    check("rst_op_a", out_op_a, 32'd0);
    rst = 1'b0;

    // mixed instruction table with varying bypass traffic; the model checks each cycle
    vec[0] = enc_i(OP_SW,   5'd1, 5'd2, 16'd8);
    vec[1] = enc_i(OP_BEQ,  5'd3, 5'd4, 16'hFFFC);
    vec[2] = enc_i(OP_ANDI, 5'd2, 5'd3, 16'h8001);
    vec[3] = enc_i(OP_SLTI, 5'd3, 5'd4, 16'h0010);
    vec[4] = {6'h3F, 5'd1, 5'd2, 16'h1234};
    vec[5] = enc_i(OP_LW,   5'd2, 5'd6, 16'd12);
    vec[6] = enc_i(OP_BNE,  5'd7, 5'd6, 16'd2);
    vec[7] = enc_i(OP_LW,   5'd1, 5'd4, 16'd0);
    vec[8] = enc_i(OP_SW,   5'd2, 5'd4, 16'd4);
    vec[9] = enc_r(5'd4, 5'd6, 5'd1, FN_SLT);
    for (int i = 0; i < 10; i++) begin
      drive(vec[i], $urandom, $urandom);
      in_pc      = 32'h200 + 32'(i * 4);
      ex_result  = $urandom;
      mem_wr_en  = 1'($urandom_range(0, 1));
      mem_wr_reg = 5'($urandom_range(0, 7));
      mem_data   = $urandom;
      wb_wr_en   = 1'($urandom_range(0, 1));
      wb_wr_reg  = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      step();
    end
    clear_bypass();
    in_valid = 1'b0;
    step();
    check("invalid_bubble", 32'(out_valid), 32'd0);
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
